// File: rtl/tdl_fifo_reader_pkg.sv
// rtl/tdl_fifo_reader_pkg.sv - shared types and defaults for the TDL FIFO reader
package tdl_fifo_reader_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int TAG_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_HALF  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  // Field order fixes the packed layout: tag occupies the most significant bits.
  typedef struct packed {
    logic [TAG_SIZE_DEF-1:0] tag;
    logic [WIDTH_DEF-1:0]    dir_x;
    logic [WIDTH_DEF-1:0]    dir_y;
    logic [WIDTH_DEF-1:0]    dir_z;
    logic [WIDTH_DEF-1:0]    len;
  } tagged_direction_len_t;

  function automatic int tdl_bits(input int width, input int tag_size);
    return tag_size + 4 * width;
  endfunction

endpackage

// File: rtl/tdl_fifo_reader_skid_buf.sv
// rtl/tdl_fifo_reader_skid_buf.sv - two-entry head/tail buffer with occupancy state machine
module tdl_skid_buf
  import tdl_fifo_reader_pkg::*;
#(
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              capture,
  input  logic              pop,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output occ_state_t        state
);

  occ_state_t        r_state;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= OCC_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_state <= OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (capture) begin
            r_head  <= in_data;
            r_state <= OCC_HALF;
          end
        end
        OCC_HALF: begin
          case ({capture, pop})
            2'b10: begin
              r_tail  <= in_data;
              r_state <= OCC_FULL;
            end
            2'b01: r_state <= OCC_EMPTY;
            // Capture and pop together: the new entry bypasses straight into head.
            2'b11: r_head <= in_data;
            default: ;
          endcase
        end
        OCC_FULL: begin
          if (pop) begin
            r_head <= r_tail;
            if (capture) r_tail <= in_data;
            else         r_state <= OCC_HALF;
          end
        end
        default: r_state <= OCC_EMPTY;
      endcase
    end
  end

  assign out_valid = (r_state != OCC_EMPTY);
  assign out_data  = r_head;
  assign state     = r_state;

endmodule

// File: rtl/tdl_fifo_reader.sv
// rtl/tdl_fifo_reader.sv - pops a TDL FIFO into a 2-entry buffer with transfer/stall counters
module tdl_fifo_reader
  import tdl_fifo_reader_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int TAG_SIZE = TAG_SIZE_DEF,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fifo_ready,
  output logic                        fifo_read,
  input  logic [TAG_SIZE+4*WIDTH-1:0] fifo_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAG_SIZE+4*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]            beat_count,
  output logic [CNT_W-1:0]            stall_count
);

  localparam int DATA_W = tdl_bits(WIDTH, TAG_SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_inflight;
  logic             r_run;
  logic [CNT_W-1:0] r_beat;
  logic [CNT_W-1:0] r_stall;
  logic             w_pop;
  logic             w_capture;
  logic [2:0]       w_level;
  occ_state_t       w_state;

  assign w_pop     = out_valid && out_ready;
  assign w_capture = r_inflight && !flush;
  // Entries held or owed after this cycle's pop; a new read is allowed only below two.
  assign w_level   = {1'b0, w_state} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_read = r_run && fifo_ready && !flush && (w_level < 3'd2);

  tdl_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .capture  (w_capture),
    .pop      (w_pop),
    .in_data  (fifo_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .state    (w_state)
  );

  // r_run holds reads off until the first clock edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
      r_beat     <= '0;
      r_stall    <= '0;
    end else begin
      r_inflight <= fifo_read;
      r_run      <= 1'b1;
      if (w_pop && (r_beat != CNT_MAX)) r_beat <= r_beat + CNT_ONE;
      if (out_valid && !out_ready && (r_stall != CNT_MAX)) r_stall <= r_stall + CNT_ONE;
    end
  end

  assign beat_count  = r_beat;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_tdl_fifo_reader.sv
// tb/tb_tdl_fifo_reader.sv - queue-model and directed checks for tdl_fifo_reader
module tb_tdl_fifo_reader;
  import tdl_fifo_reader_pkg::*;

  localparam int WIDTH    = 8;
  localparam int TAG_SIZE = 8;
  localparam int CNT_W    = 4;
  localparam int DW       = TAG_SIZE + 4 * WIDTH;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;
  wire               fifo_ready;
  logic              fifo_read;
  logic [DW-1:0]     fifo_data = '0;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [CNT_W-1:0]  beat_count;
  logic [CNT_W-1:0]  stall_count;

  int checks = 0;
  int failures = 0;

  // Upstream FIFO contents; written by the stimulus, drained by the environment process.
  logic [DW-1:0] mem [0:127];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  assign fifo_ready = (wr_ptr != rd_ptr);

  // Model: entries owned by the reader (buffered) plus the one owed by the FIFO.
  logic [DW-1:0]       mq[$];
  bit                  pend = 0;
  logic [DW-1:0]       pend_data = '0;
  bit                  run = 0;
  int                  beat_m = 0;
  int                  stall_m = 0;
  logic [TAG_SIZE-1:0] got [0:255];
  int                  got_n = 0;

  tdl_fifo_reader #(
    .WIDTH(WIDTH),
    .TAG_SIZE(TAG_SIZE),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_ready (fifo_ready),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .beat_count (beat_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] mk(input logic [7:0] t);
    tagged_direction_len_t e;
    e.tag   = t;
    e.dir_x = t + 8'd1;
    e.dir_y = ~t;
    e.dir_z = t ^ 8'h5A;
    e.len   = t + 8'd3;
    return e;
  endfunction

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) mem[wr_ptr + i] = mk(8'(first + i));
    wr_ptr = wr_ptr + n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      pend = 0;
      run = 0;
      beat_m = 0;
      stall_m = 0;
    end else begin
      bit mval;
      bit mpop;
      mval = (mq.size() > 0);
      mpop = mval && out_ready;
      if (mpop && beat_m < CNT_MAX) beat_m++;
      if (mval && !out_ready && stall_m < CNT_MAX) stall_m++;
      if (mpop) begin
        got[got_n] = mq[0][DW-1 -: TAG_SIZE];
        got_n++;
        void'(mq.pop_front());
      end
      if (flush) begin
        mq.delete();
        pend = 0;
      end else if (pend) begin
        mq.push_back(pend_data);
      end
      pend = fifo_read;
      if (fifo_read) begin
        pend_data = mem[rd_ptr];
        fifo_data <= mem[rd_ptr];
        rd_ptr++;
      end
      run = 1;
    end
  end

  always @(negedge clk) begin
    #2;
    begin
      int  lvl;
      bit  exp_rd;
      lvl = mq.size() + int'(pend) - ((mq.size() > 0 && out_ready) ? 1 : 0);
      exp_rd = run && fifo_ready && !flush && (lvl < 2);
      chk("m_out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) chk("m_out_data", out_data, mq[0]);
      chk("m_fifo_read", fifo_read, exp_rd);
      chk("m_beat_count", beat_count, beat_m);
      chk("m_stall_count", stall_count, stall_m);
    end
  end

  initial begin
    int g0;
    int pulses;

    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_read", fifo_read, 0);
    chk("rst_beat", beat_count, 0);
    chk("rst_stall", stall_count, 0);

    // Streaming: tags 1..8 with out_ready held high.
    do_reset();
    load(1, 8);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("st_fifo_read", fifo_read, i < 8);
      chk("st_out_valid", out_valid, (i >= 2) && (i < 10));
      if (i >= 2 && i < 10) chk("st_tag", out_data[DW-1 -: TAG_SIZE], i - 1);
      @(negedge clk);
    end
    chk("st_beat", beat_count, 8);
    chk("st_stall", stall_count, 0);

    // Backpressure: four entries, downstream stalled for ten cycles.
    do_reset();
    load(1, 4);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (fifo_read) pulses++;
      @(negedge clk);
    end
    #1;
    chk("bp_pulses", pulses, 2);
    chk("bp_state", dut.w_state, OCC_FULL);
    chk("bp_stall", stall_count, 8);
    g0 = got_n;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_count", got_n - g0, 4);
    for (int i = 0; i < 4; i++) chk("bp_tag", got[g0 + i], i + 1);

    // Alternating downstream ready: tags 0x10..0x1F.
    do_reset();
    load(16, 16);
    g0 = got_n;
    for (int i = 0; i < 44; i++) begin
      out_ready = (i % 2 == 0);
      @(negedge clk);
    end
    chk("alt_count", got_n - g0, 16);
    for (int i = 0; i < 16; i++) chk("alt_tag", got[g0 + i], 16 + i);
    chk("alt_beat_sat", beat_count, 15);

    // Flush with a full buffer while stalled: tags 5,6 dropped, 7 comes next.
    do_reset();
    load(5, 4);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fa_read_low", fifo_read, 0);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("fa_out_valid", out_valid, 0);
    chk("fa_stall", stall_count, 2);
    g0 = got_n;
    repeat (6) @(negedge clk);
    chk("fa_count", got_n - g0, 2);
    chk("fa_tag0", got[g0], 7);
    chk("fa_tag1", got[g0 + 1], 8);

    // Flush while streaming: the coincident pop still counts, the in-flight entry is lost.
    do_reset();
    out_ready = 1'b1;
    g0 = got_n;
    load(32, 8);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fb_head", out_data[DW-1 -: TAG_SIZE], 8'h22);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fb_out_valid", out_valid, 0);
    chk("fb_beat", beat_count, 3);
    repeat (10) @(negedge clk);
    chk("fb_count", got_n - g0, 7);
    chk("fb_tag2", got[g0 + 2], 8'h22);
    chk("fb_tag3", got[g0 + 3], 8'h24);
    chk("fb_tag6", got[g0 + 6], 8'h27);

    // Asynchronous reset mid-stream at a non-aligned time.
    do_reset();
    out_ready = 1'b1;
    load(48, 16);
    repeat (5) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_fifo_read", fifo_read, 0);
    chk("ar_beat", beat_count, 0);
    chk("ar_stall", stall_count, 0);
    g0 = got_n;
    #12;
    reset = 1'b0;
    repeat (18) @(negedge clk);
    chk("ar_count", got_n - g0, 11);
    chk("ar_first", got[g0], 8'h35);
    chk("ar_last", got[g0 + 10], 8'h3F);
    chk("ar_beat_after", beat_count, 11);

    // Counter saturation: 20 beats into a 4-bit counter.
    do_reset();
    out_ready = 1'b1;
    g0 = got_n;
    load(64, 20);
    repeat (26) @(negedge clk);
    chk("sat_count", got_n - g0, 20);
    chk("sat_beat", beat_count, 15);
    chk("sat_stall", stall_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
